// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants and types for the AES ciphertext drain stage
package aes_pkg;

   localparam int AES_FWD_WORDS = 22;
   localparam int AES_CT_LO_IDX = 0;
   localparam int AES_CT_HI_IDX = 1;

   typedef logic [127:0] ct_block_t;

   typedef enum logic {
      S_WORD0 = 1'b0,
      S_WORD1 = 1'b1
   } drain_state_t;

endpackage

// File: rtl/aes_ct_fifo.sv
// rtl/aes_ct_fifo.sv - synchronous FIFO of ciphertext blocks
module aes_ct_fifo
   import aes_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  ct_block_t                data,
   input  logic                     pop,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output ct_block_t                head
);

   localparam int AW = $clog2(DEPTH);

   ct_block_t        mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a block when the head leaves on the same edge.
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= data;
   end

endmodule

// File: rtl/aes_ct_drain.sv
// rtl/aes_ct_drain.sv - final AES stage: capture ciphertext, buffer it, stream as 64-bit beats
module aes_ct_drain
   import aes_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int NUM_WORDS = AES_FWD_WORDS,
   parameter bit LOW_FIRST = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          fwd_rdy,
   input  logic [NUM_WORDS-1:0][63:0]    fwd_data,
   output logic                          prod_valid,
   input  logic                          prod_ready,
   output logic [63:0]                   prod_data,
   output logic                          overflow,
   input  logic                          clr_overflow,
   output logic [$clog2(DEPTH):0]        fifo_level,
   output logic [31:0]                   blocks_done
);

   drain_state_t  state;
   drain_state_t  state_next;
   ct_block_t     head;
   logic          fwd_rdy_q;
   logic          cap;
   logic          pop;
   logic          full;
   logic          empty;
   logic          handshake;
   logic [63:0]   first_word;
   logic [63:0]   second_word;
   logic          unused_round_keys;

   // Round keys travel with the bundle but are not needed past the last round.
   assign unused_round_keys = ^fwd_data[NUM_WORDS-1:2];

   assign cap        = fwd_rdy & ~fwd_rdy_q;
   assign prod_valid = ~empty;
   assign handshake  = prod_valid & prod_ready;

   aes_ct_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cap),
      .data  ({fwd_data[AES_CT_HI_IDX], fwd_data[AES_CT_LO_IDX]}),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .level (fifo_level),
      .head  (head)
   );

   assign first_word  = LOW_FIRST ? head[63:0]   : head[127:64];
   assign second_word = LOW_FIRST ? head[127:64] : head[63:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_WORD0;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      prod_data  = '0;
      if (!empty) prod_data = (state == S_WORD0) ? first_word : second_word;
      case (state)
         S_WORD0: if (handshake) state_next = S_WORD1;
         S_WORD1: if (handshake) begin
            state_next = S_WORD0;
            pop        = 1'b1;
         end
         default: state_next = S_WORD0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_rdy_q   <= 1'b0;
         overflow    <= 1'b0;
         blocks_done <= '0;
      end else begin
         fwd_rdy_q <= fwd_rdy;
         if (cap && full && !pop) overflow <= 1'b1;
         else if (clr_overflow)   overflow <= 1'b0;
         if (pop) blocks_done <= blocks_done + 1'b1;
      end
   end

endmodule

// File: tb/tb_aes_ct_drain.sv
// tb/tb_aes_ct_drain.sv - directed self-checking bench for aes_ct_drain
module tb_aes_ct_drain;
   import aes_pkg::*;

   logic                    clk;
   logic                    rst_n;
   logic                    fwd_rdy;
   logic [21:0][63:0]       fwd_data;
   logic                    prod_valid;
   logic                    prod_ready;
   logic [63:0]             prod_data;
   logic                    overflow;
   logic                    clr_overflow;
   logic [2:0]              fifo_level;
   logic [31:0]             blocks_done;

   int checks = 0;
   int fails  = 0;

   aes_ct_drain #(.DEPTH(4), .NUM_WORDS(22), .LOW_FIRST(1'b1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .fwd_rdy      (fwd_rdy),
      .fwd_data     (fwd_data),
      .prod_valid   (prod_valid),
      .prod_ready   (prod_ready),
      .prod_data    (prod_data),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .fifo_level   (fifo_level),
      .blocks_done  (blocks_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_block(input logic [63:0] lo, input logic [63:0] hi);
      for (int w = 2; w < 22; w++) fwd_data[w] = 64'hDEAD_0000 + 64'(w);
      fwd_data[0] = lo;
      fwd_data[1] = hi;
   endtask

   task automatic push_block(input logic [63:0] lo, input logic [63:0] hi);
      set_block(lo, hi);
      fwd_rdy = 1'b1;
      step();
      fwd_rdy = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; fwd_rdy = 1'b0; prod_ready = 1'b0; clr_overflow = 1'b0;
      set_block(64'h0, 64'h0);
      step(); step();
      checks++; if (prod_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", prod_valid); end
      checks++; if (prod_data !== 64'h0) begin fails++; $display("FAIL reset_data got %h want 0", prod_data); end
      checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %0b want 0", overflow); end
      checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d want 0", fifo_level); end
      checks++; if (blocks_done !== 32'd0) begin fails++; $display("FAIL reset_done got %0d want 0", blocks_done); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_block();
      prod_ready = 1'b1;
      set_block(64'h1111, 64'h2222);
      fwd_rdy = 1'b1;
      checks++; if (prod_valid !== 1'b0) begin fails++; $display("FAIL t1_valid_n got %0b want 0", prod_valid); end
      step();
      fwd_rdy = 1'b0;
      checks++; if (prod_valid !== 1'b1 || prod_data !== 64'h1111) begin fails++; $display("FAIL t1_beat0 got %0b/%h want 1/1111", prod_valid, prod_data); end
      step();
      checks++; if (prod_valid !== 1'b1 || prod_data !== 64'h2222) begin fails++; $display("FAIL t1_beat1 got %0b/%h want 1/2222", prod_valid, prod_data); end
      step();
      checks++; if (prod_valid !== 1'b0) begin fails++; $display("FAIL t1_idle got %0b want 0", prod_valid); end
      checks++; if (blocks_done !== 32'd1) begin fails++; $display("FAIL t1_done got %0d want 1", blocks_done); end
      checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL t1_level got %0d want 0", fifo_level); end
   endtask

   task automatic test_level_hold();
      prod_ready = 1'b0;
      set_block(64'h3333, 64'h4444);
      fwd_rdy = 1'b1;
      repeat (5) step();
      fwd_rdy = 1'b0;
      step();
      checks++; if (fifo_level !== 3'd1) begin fails++; $display("FAIL t2_level got %0d want 1", fifo_level); end
      prod_ready = 1'b1;
      step(); step();
      prod_ready = 1'b0;
      checks++; if (fifo_level !== 3'd0 || blocks_done !== 32'd2) begin fails++; $display("FAIL t2_drain got %0d/%0d want 0/2", fifo_level, blocks_done); end
   endtask

   task automatic test_back_pressure();
      prod_ready = 1'b0;
      for (int b = 0; b < 3; b++) push_block(64'hA00 + 64'(b), 64'hB00 + 64'(b));
      checks++; if (fifo_level !== 3'd3) begin fails++; $display("FAIL t3_level got %0d want 3", fifo_level); end
      for (int c = 0; c < 3; c++) begin
         checks++; if (prod_valid !== 1'b1 || prod_data !== 64'hA00) begin fails++; $display("FAIL t3_hold got %0b/%h want 1/a00", prod_valid, prod_data); end
         step();
      end
      prod_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         checks++; if (prod_data !== 64'hA00 + 64'(b)) begin fails++; $display("FAIL t3_lo%0d got %h want %h", b, prod_data, 64'hA00 + 64'(b)); end
         step();
         checks++; if (prod_data !== 64'hB00 + 64'(b)) begin fails++; $display("FAIL t3_hi%0d got %h want %h", b, prod_data, 64'hB00 + 64'(b)); end
         step();
      end
      prod_ready = 1'b0;
      checks++; if (blocks_done !== 32'd5 || prod_valid !== 1'b0) begin fails++; $display("FAIL t3_done got %0d/%0b want 5/0", blocks_done, prod_valid); end
   endtask

   task automatic test_overflow();
      prod_ready = 1'b0;
      for (int b = 0; b < 4; b++) push_block(64'hC00 + 64'(b), 64'hD00 + 64'(b));
      checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL t4_ovf_pre got %0b want 0", overflow); end
      push_block(64'hEEEE, 64'hFFFF);
      checks++; if (fifo_level !== 3'd4 || overflow !== 1'b1) begin fails++; $display("FAIL t4_full got %0d/%0b want 4/1", fifo_level, overflow); end
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL t4_clr got %0b want 0", overflow); end
      prod_ready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         checks++; if (prod_data !== 64'hC00 + 64'(b)) begin fails++; $display("FAIL t4_lo%0d got %h want %h", b, prod_data, 64'hC00 + 64'(b)); end
         step();
         checks++; if (prod_data !== 64'hD00 + 64'(b)) begin fails++; $display("FAIL t4_hi%0d got %h want %h", b, prod_data, 64'hD00 + 64'(b)); end
         step();
      end
      prod_ready = 1'b0;
      checks++; if (prod_valid !== 1'b0 || blocks_done !== 32'd9) begin fails++; $display("FAIL t4_drop got %0b/%0d want 0/9", prod_valid, blocks_done); end
   endtask

   task automatic test_full_pop();
      logic [63:0] lo_exp;
      logic [63:0] hi_exp;
      prod_ready = 1'b0;
      for (int b = 0; b < 4; b++) push_block(64'h500 + 64'(b), 64'h600 + 64'(b));
      prod_ready = 1'b1;
      checks++; if (prod_data !== 64'h500) begin fails++; $display("FAIL t5_w0 got %h want 500", prod_data); end
      step();
      set_block(64'h777, 64'h888);
      fwd_rdy = 1'b1;
      checks++; if (prod_data !== 64'h600) begin fails++; $display("FAIL t5_w1 got %h want 600", prod_data); end
      step();
      fwd_rdy = 1'b0;
      checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin fails++; $display("FAIL t5_accept got %0d/%0b want 4/0", fifo_level, overflow); end
      for (int b = 1; b < 5; b++) begin
         lo_exp = (b == 4) ? 64'h777 : 64'h500 + 64'(b);
         hi_exp = (b == 4) ? 64'h888 : 64'h600 + 64'(b);
         checks++; if (prod_data !== lo_exp) begin fails++; $display("FAIL t5_lo%0d got %h want %h", b, prod_data, lo_exp); end
         step();
         checks++; if (prod_data !== hi_exp) begin fails++; $display("FAIL t5_hi%0d got %h want %h", b, prod_data, hi_exp); end
         step();
      end
      prod_ready = 1'b0;
      checks++; if (fifo_level !== 3'd0 || blocks_done !== 32'd14) begin fails++; $display("FAIL t5_done got %0d/%0d want 0/14", fifo_level, blocks_done); end
   endtask

   task automatic test_reset_mid_block();
      prod_ready = 1'b1;
      set_block(64'h9A9A, 64'h9B9B);
      fwd_rdy = 1'b1;
      step();
      fwd_rdy = 1'b0;
      step();
      checks++; if (prod_data !== 64'h9B9B) begin fails++; $display("FAIL t6_w1 got %h want 9b9b", prod_data); end
      rst_n = 1'b0;
      #1;
      checks++; if (prod_valid !== 1'b0 || fifo_level !== 3'd0) begin fails++; $display("FAIL t6_rst got %0b/%0d want 0/0", prod_valid, fifo_level); end
      checks++; if (blocks_done !== 32'd0) begin fails++; $display("FAIL t6_done got %0d want 0", blocks_done); end
      step();
      rst_n = 1'b1;
      step();
      set_block(64'h4C4C, 64'h4D4D);
      fwd_rdy = 1'b1;
      step();
      fwd_rdy = 1'b0;
      checks++; if (prod_valid !== 1'b1 || prod_data !== 64'h4C4C) begin fails++; $display("FAIL t6_restart got %0b/%h want 1/4c4c", prod_valid, prod_data); end
      step();
      checks++; if (prod_data !== 64'h4D4D) begin fails++; $display("FAIL t6_restart_hi got %h want 4d4d", prod_data); end
      step();
      prod_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_level_hold();
      test_back_pressure();
      test_overflow();
      test_full_pop();
      test_reset_mid_block();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
